syzygy_dac_cfg_seq: RTL and testbench
=====================================

Name: syzygy_dac_cfg_seq

Overview:
Sequencer that owns the control side of the SYZYGY DAC Pod SPI engine (AD911x).
- After reset, writes a parameterised table of register/data pairs to the DAC.
- Then serves single-register read/write requests from a host port (e.g. a host endpoint bridge).
- All SPI traffic is issued through this block; it presents status flags to the rest of the design.

Parameters:
INIT_LEN, 4, number of init-table entries (1..32)
INIT_TABLE, 56'h0, packed table; entry i = bits [14*i+13:14*i] = {reg[5:0], data[7:0]}; entry 0 sent first
STARTUP_CYCLES, 1024, clk cycles to wait after reset before first transaction
TIMEOUT_CYCLES, 65535, max clk cycles allowed in any single wait state before abort

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
spi_reg  output  6  register address to SPI engine
spi_data_in  output  8  write data to SPI engine
spi_rw  output  1  0 = read, 1 = write
spi_send  output  1  start pulse to SPI engine
spi_done  input  1  engine idle / read data valid
spi_data_out  input  8  read data from engine
host_req  input  1  host request (level; held until host_ack)
host_rw  input  1  0 = read, 1 = write
host_reg  input  6  host register address
host_wdata  input  8  host write data
host_ack  output  1  one-cycle completion pulse
host_rdata  output  8  read data; valid when host_ack = 1
host_err  output  1  qualifies host_ack; 1 = transaction timed out
init_done  output  1  init table complete; host port open
init_error  output  1  sticky; set by any init failure
busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset values:
  - spi_send, host_ack, host_err, init_done, init_error = 0
  - spi_reg, spi_data_in, host_rdata = 0
  - spi_rw = 1
  - busy = 1
  - state = STARTUP, index = 0, counters = 0
- Reset asserted mid-transaction aborts immediately to STARTUP. There is no attempt to finish the SPI frame; the engine is reset from the same reset.
- States:
  - STARTUP: count STARTUP_CYCLES. Move to INIT_ISSUE when the count expires and spi_done = 1.
  - INIT_ISSUE:
    - Drive spi_reg/spi_data_in from entry[index] and spi_rw = 1.
    - Assert spi_send for exactly this one cycle.
    - Next state: WAIT_LOW.
  - WAIT_LOW: wait for spi_done = 0 (the engine acknowledges one cycle after send).
  - WAIT_HIGH: wait for spi_done = 1. On completion:
    - Init write: index++. If index == INIT_LEN-1 was just sent, go to IDLE and set init_done = 1; else go to INIT_ISSUE.
    - Host transaction: go to HOST_ACK.
  - IDLE:
    - busy = 0.
    - If host_req = 1, latch host_rw/host_reg/host_wdata into spi_rw/spi_reg/spi_data_in and go to HOST_ISSUE.
  - HOST_ISSUE: one-cycle spi_send, then WAIT_LOW.
  - HOST_ACK:
    - host_ack = 1 for one cycle.
    - host_rdata = spi_data_out captured on the cycle spi_done was seen high (reads only; unchanged on writes).
    - Return to IDLE.
    - host_req must drop before the next IDLE cycle, otherwise it is treated as a new request.
- spi_reg, spi_data_in and spi_rw stay stable from the ISSUE cycle until WAIT_HIGH exits. The engine samples them throughout the frame.
- spi_send never asserts while spi_done = 0.
- Timeout:
  - A counter of TIMEOUT_CYCLES runs in WAIT_LOW/WAIT_HIGH and resets on each state entry.
  - Expiry during init: set init_error, skip the entry, continue with the next one.
  - Expiry during a host transaction: HOST_ACK with host_err = 1 and host_rdata unchanged.
- host_req during STARTUP or init is ignored (held off, not dropped). It is serviced on the first IDLE cycle.
- INIT_LEN = 1: a single write, then IDLE.
- The index counter is 5 bits wide and never wraps past INIT_LEN-1.

Optional Feature:
DAC_CFG_VERIFY_EN
- Defined:
  - After each init write completes, issue a read of the same register: spi_rw = 0, same spi_reg, spi_data_in = 0.
  - Use the same ISSUE/WAIT_LOW/WAIT_HIGH path.
  - Compare spi_data_out against the table data. A mismatch sets init_error (sticky).
  - Output verify_fail_idx [4:0] holds the index of the first mismatching entry (reset 0).
  - Init takes 2*INIT_LEN transactions.
- Undefined:
  - No readback and no verify_fail_idx port.
  - init_error is set only by timeouts.

Test Plan:
- INIT_LEN = 2, table {6'h02,8'h80},{6'h03,8'h40}, model engine (spi_done low 1 cycle after send, high 300 cycles later):
  - Expect exactly two spi_send pulses, with spi_reg 02 then 03 and spi_rw = 1 held over each frame.
  - Expect init_done = 1 and busy = 0 afterwards.
- After init, host read reg 6'h1F with the model returning 8'hA5 -> single host_ack, host_rdata = 8'hA5, host_err = 0, spi_rw = 0 during the frame.
- host_req asserted during STARTUP -> no spi_send before init_done; host transaction issues on the first IDLE cycle, after the last init write.
- Model never drops spi_done in entry 0, TIMEOUT_CYCLES = 100 -> init_error = 1 after ~101 cycles; entry 1 is still sent; init_done = 1.
- Reset pulsed mid-frame of entry 1 -> spi_send = 0, init_done = 0, index = 0; the full sequence reruns from entry 0 after STARTUP_CYCLES.
- DAC_CFG_VERIFY_EN defined, model returns 8'h00 for reg 03 -> init_error = 1, verify_fail_idx = 1, four spi_send pulses in the order W02, R02, W03, R03.

Source files
------------

// File: rtl/syzygy_dac_cfg_seq_if.sv
// Signal bundles for the DAC configuration sequencer: the SPI-engine control
// side and the single-register host request port.

interface syzygy_dac_spi_if;
  logic [5:0] spi_reg;
  logic [7:0] spi_data_in;
  logic       spi_rw;
  logic       spi_send;
  logic       spi_done;
  logic [7:0] spi_data_out;

  modport master (
    output spi_reg, spi_data_in, spi_rw, spi_send,
    input  spi_done, spi_data_out
  );
  modport slave (
    input  spi_reg, spi_data_in, spi_rw, spi_send,
    output spi_done, spi_data_out
  );
endinterface

interface syzygy_dac_host_if;
  logic       host_req;
  logic       host_rw;
  logic [5:0] host_reg;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_err;

  modport master (
    output host_req, host_rw, host_reg, host_wdata,
    input  host_ack, host_rdata, host_err
  );
  modport slave (
    input  host_req, host_rw, host_reg, host_wdata,
    output host_ack, host_rdata, host_err
  );
endinterface

// File: rtl/syzygy_dac_cfg_seq.sv
// AD911x control sequencer: writes the init table after reset, then serves host register requests.
// Define DAC_CFG_VERIFY_EN to read back every init write and flag the first mismatching entry.

module syzygy_dac_cfg_seq #(
  parameter int                      INIT_LEN       = 4,
  parameter logic [14*INIT_LEN-1:0]  INIT_TABLE     = '0,
  parameter int                      STARTUP_CYCLES = 1024,
  parameter int                      TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  syzygy_dac_spi_if.master  spi,
  syzygy_dac_host_if.slave  host,
  output logic              init_done,
  output logic              init_error,
`ifdef DAC_CFG_VERIFY_EN
  output logic [4:0]        verify_fail_idx,
`endif
  output logic              busy
);

  localparam int CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STARTUP_END = CNT_W'(STARTUP_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
  localparam logic [4:0]       LAST_IDX    = 5'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_INIT_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_HOST_ISSUE,
    ST_HOST_ACK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_idx;
  logic [5:0]       r_spi_reg;
  logic [7:0]       r_spi_data;
  logic             r_spi_rw;
  logic [7:0]       r_host_rdata;
  logic             r_host_err;
  logic             r_init_done;
  logic             r_init_error;

  logic w_issue;
  logic w_waiting;
  logic w_progress;
  logic w_timeout;
  logic w_frame_end;
  logic w_start;
  logic w_last;
  logic w_go_verify;
  logic w_advance;

  function automatic logic [13:0] tbl_entry(input logic [4:0] idx);
    return INIT_TABLE[14*int'(idx) +: 14];
  endfunction

  assign w_issue    = (r_state == ST_INIT_ISSUE) || (r_state == ST_HOST_ISSUE);
  assign w_waiting  = (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH);
  // ISSUE holds off until the engine is idle so a send never lands while spi_done is low
  assign w_progress = (r_state == ST_WAIT_LOW) ? !spi.spi_done : spi.spi_done;
  assign w_timeout  = (w_issue || w_waiting) && !w_progress && (r_cnt == TIMEOUT_END);
  assign w_frame_end = ((r_state == ST_WAIT_HIGH) && spi.spi_done) || w_timeout;
  assign w_start    = (r_state == ST_STARTUP) && (r_cnt == STARTUP_END) && spi.spi_done;
  assign w_last     = (r_idx == LAST_IDX);
  // r_init_done doubles as the "frame belongs to the host" flag
  assign w_advance  = w_frame_end && !r_init_done && !w_go_verify;

`ifdef DAC_CFG_VERIFY_EN
  logic       r_verify;
  logic       r_vfail_seen;
  logic [4:0] r_vfail_idx;
  logic [7:0] w_cur_data;

  assign w_cur_data  = INIT_TABLE[14*int'(r_idx) +: 8];
  // a timed-out write skips its readback
  assign w_go_verify = w_frame_end && !r_init_done && !r_verify && !w_timeout;
  assign verify_fail_idx = r_vfail_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_verify     <= 1'b0;
      r_vfail_seen <= 1'b0;
      r_vfail_idx  <= 5'd0;
    end else begin
      if (w_go_verify) begin
        r_verify <= 1'b1;
      end else if (w_advance) begin
        r_verify <= 1'b0;
      end
      if (w_frame_end && !w_timeout && r_verify && !r_init_done &&
          (spi.spi_data_out != w_cur_data) && !r_vfail_seen) begin
        r_vfail_seen <= 1'b1;
        r_vfail_idx  <= r_idx;
      end
    end
  end

  logic w_verify_mismatch;
  assign w_verify_mismatch = w_frame_end && !w_timeout && r_verify && !r_init_done &&
                             (spi.spi_data_out != w_cur_data);
`else
  logic w_verify_mismatch;
  assign w_go_verify       = 1'b0;
  assign w_verify_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STARTUP:                   if (w_start) w_state_next = ST_INIT_ISSUE;
      ST_INIT_ISSUE, ST_HOST_ISSUE: if (w_progress) w_state_next = ST_WAIT_LOW;
      ST_WAIT_LOW:                  if (w_progress) w_state_next = ST_WAIT_HIGH;
      ST_IDLE:                      if (host.host_req) w_state_next = ST_HOST_ISSUE;
      ST_HOST_ACK:                  w_state_next = ST_IDLE;
      default:                      w_state_next = r_state;
    endcase
    // completion or timeout of any frame decides where the sequence goes next
    if (w_frame_end) begin
      if (r_init_done) begin
        w_state_next = ST_HOST_ACK;
      end else if (w_go_verify || !w_last) begin
        w_state_next = ST_INIT_ISSUE;
      end else begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_comb begin
    spi.spi_send   = 1'b0;
    host.host_ack  = 1'b0;
    host.host_err  = 1'b0;
    busy           = 1'b1;
    case (r_state)
      ST_INIT_ISSUE, ST_HOST_ISSUE: spi.spi_send = spi.spi_done;
      ST_IDLE:                      busy = 1'b0;
      ST_HOST_ACK: begin
        host.host_ack = 1'b1;
        host.host_err = r_host_err;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= 5'd0;
      r_spi_reg    <= 6'd0;
      r_spi_data   <= 8'd0;
      r_spi_rw     <= 1'b1;
      r_host_rdata <= 8'd0;
      r_host_err   <= 1'b0;
      r_init_done  <= 1'b0;
      r_init_error <= 1'b0;
    end else begin
      // frame end also clears, since a skipped entry may re-enter INIT_ISSUE from INIT_ISSUE
      if ((w_state_next != r_state) || w_frame_end) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_start) begin
        {r_spi_reg, r_spi_data} <= tbl_entry(5'd0);
        r_spi_rw                <= 1'b1;
      end

      if (w_go_verify) begin
        r_spi_rw   <= 1'b0;
        r_spi_data <= 8'd0;
      end

      if (w_advance) begin
        if (w_last) begin
          r_init_done <= 1'b1;
        end else begin
          r_idx                   <= r_idx + 5'd1;
          {r_spi_reg, r_spi_data} <= tbl_entry(r_idx + 5'd1);
          r_spi_rw                <= 1'b1;
        end
      end

      if ((w_timeout && !r_init_done) || w_verify_mismatch) begin
        r_init_error <= 1'b1;
      end

      if ((r_state == ST_IDLE) && host.host_req) begin
        r_spi_rw   <= host.host_rw;
        r_spi_reg  <= host.host_reg;
        r_spi_data <= host.host_wdata;
      end

      if (w_frame_end && r_init_done) begin
        r_host_err <= w_timeout;
        if (!w_timeout && !r_spi_rw) begin
          r_host_rdata <= spi.spi_data_out;
        end
      end
    end
  end

  assign spi.spi_reg     = r_spi_reg;
  assign spi.spi_data_in = r_spi_data;
  assign spi.spi_rw      = r_spi_rw;
  assign host.host_rdata = r_host_rdata;
  assign init_done       = r_init_done;
  assign init_error      = r_init_error;

endmodule

// File: tb/tb_syzygy_dac_cfg_seq.sv
// Bench for syzygy_dac_cfg_seq: behavioural SPI engine, expected-transaction queues and directed scenarios.
// Follows DAC_CFG_VERIFY_EN when it is defined for the build.

module tb_syzygy_dac_cfg_seq;
  localparam int          INIT_LEN = 2;
  localparam int          STARTUP  = 20;
  localparam int          TIMEOUT  = 100;
  localparam int          FRAME    = 40;
  localparam logic [27:0] TABLE    = {6'h03, 8'h40, 6'h02, 8'h80};
`ifdef DAC_CFG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct packed { logic rw; logic [5:0] r; logic [7:0] d; } txn_t;
  typedef struct packed { logic [7:0] rd; logic err; } hrsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done, init_error, busy;
`ifdef DAC_CFG_VERIFY_EN
  logic [4:0] verify_fail_idx;
`endif

  syzygy_dac_spi_if  spi();
  syzygy_dac_host_if host();

  syzygy_dac_cfg_seq #(
    .INIT_LEN(INIT_LEN), .INIT_TABLE(TABLE),
    .STARTUP_CYCLES(STARTUP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .spi(spi), .host(host),
    .init_done(init_done), .init_error(init_error),
`ifdef DAC_CFG_VERIFY_EN
    .verify_fail_idx(verify_fail_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cyc = 0;
  txn_t  exp_q[$];
  hrsp_t hexp_q[$];
  int    send_cyc[$];
  logic [5:0] t_reg [INIT_LEN] = '{6'h02, 6'h03};
  logic [7:0] t_dat [INIT_LEN] = '{8'h80, 8'h40};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: drops spi_done on the edge that sees spi_send, raises it FRAME cycles later.
  bit         stuck_en  = 1'b0;
  logic [5:0] stuck_reg = 6'h00;
  bit         corrupt03 = 1'b0;
  int         eng_cnt;
  logic       eng_rw;
  logic [5:0] eng_reg;
  logic [7:0] eng_wd;
  logic [7:0] eng_mem [64];

  function automatic logic [7:0] eng_read(input logic [5:0] r);
    if (r == 6'h1F) return 8'hA5;
    if (corrupt03 && r == 6'h03) return 8'h00;
    return eng_mem[r];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      spi.spi_done     <= 1'b1;
      spi.spi_data_out <= 8'h00;
      eng_cnt          <= 0;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        spi.spi_done <= 1'b1;
        if (eng_rw) eng_mem[eng_reg] <= eng_wd;
        else        spi.spi_data_out <= eng_read(eng_reg);
      end
    end else if (spi.spi_send && spi.spi_done && !(stuck_en && spi.spi_reg == stuck_reg)) begin
      spi.spi_done <= 1'b0;
      eng_cnt      <= FRAME;
      eng_rw       <= spi.spi_rw;
      eng_reg      <= spi.spi_reg;
      eng_wd       <= spi.spi_data_in;
    end
  end

  // Compare process: every send against the expected queue, frame stability, every ack.
  txn_t  cur, e;
  hrsp_t h;
  bit    in_frame = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (spi.spi_send) begin
        $display("txn send rw=%0d reg=%02h data=%02h cycle=%0d", spi.spi_rw, spi.spi_reg, spi.spi_data_in, cyc);
        chk("send_with_done_high", spi.spi_done, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_send_queue_len", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("send_rw", spi.spi_rw, e.rw);
          chk("send_reg", spi.spi_reg, e.r);
          chk("send_data", spi.spi_data_in, e.d);
        end
        cur = {spi.spi_rw, spi.spi_reg, spi.spi_data_in};
        in_frame = 1'b1;
        send_cyc.push_back(cyc);
      end else if (in_frame) begin
        chk("frame_stable", {spi.spi_rw, spi.spi_reg, spi.spi_data_in}, cur);
        if (spi.spi_done) in_frame = 1'b0;
      end
      if (host.host_ack) begin
        $display("txn ack rdata=%02h err=%0d cycle=%0d", host.host_rdata, host.host_err, cyc);
        if (hexp_q.size() == 0) begin
          chk("unexpected_ack_queue_len", 1, 0);
        end else begin
          h = hexp_q.pop_front();
          chk("ack_rdata", host.host_rdata, h.rd);
          chk("ack_err", host.host_err, h.err);
        end
      end
    end
  end

  task automatic push_init(input bit skip_rb0);
    for (int i = 0; i < INIT_LEN; i++) begin
      exp_q.push_back(txn_t'{1'b1, t_reg[i], t_dat[i]});
      if (VERIFY && !(skip_rb0 && i == 0)) exp_q.push_back(txn_t'{1'b0, t_reg[i], 8'h00});
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    hexp_q.delete();
    send_cyc.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic wait_init(input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_within_budget", init_done, 1);
  endtask

  task automatic wait_ack(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host.host_ack && n < budget);
    chk("host_ack_within_budget", host.host_ack, 1);
  endtask

  task automatic host_txn(input logic rw, input logic [5:0] r, input logic [7:0] d,
                          input logic [7:0] exp_rd, input logic exp_err);
    exp_q.push_back(txn_t'{rw, r, d});
    hexp_q.push_back(hrsp_t'{exp_rd, exp_err});
    host.host_rw    = rw;
    host.host_reg   = r;
    host.host_wdata = d;
    host.host_req   = 1'b1;
    wait_ack(2000);
    host.host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic drained(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_spi_queue_left"}, exp_q.size(), 0);
    chk({tag, "_ack_queue_left"}, hexp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    int n;
    host.host_req = 1'b0; host.host_rw = 1'b0; host.host_reg = 6'h00; host.host_wdata = 8'h00;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_send", spi.spi_send, 0);
    chk("rst_host_ack", host.host_ack, 0);
    chk("rst_host_err", host.host_err, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_init_error", init_error, 0);
    chk("rst_spi_reg", spi.spi_reg, 0);
    chk("rst_spi_data_in", spi.spi_data_in, 0);
    chk("rst_host_rdata", host.host_rdata, 0);
    chk("rst_spi_rw", spi.spi_rw, 1);
    chk("rst_busy", busy, 1);
`ifdef DAC_CFG_VERIFY_EN
    chk("rst_verify_fail_idx", verify_fail_idx, 0);
`endif

    // plain init sequence
    push_init(1'b0);
    reset = 1'b0;
    rst_cyc = cyc;
    wait_init(1000);
    chk("init_busy_low", busy, 0);
    chk("init_error_clean", init_error, 0);
    chk("init_send_count", send_cyc.size(), VERIFY ? 4 : 2);
    chk("startup_wait_respected", (send_cyc.size() > 0 && send_cyc[0] - rst_cyc >= STARTUP), 1);
    drained("init");

    // host read, write, read-back
    host_txn(1'b0, 6'h1F, 8'h00, 8'hA5, 1'b0);
    chk("host_rdata_literal_a5", host.host_rdata, 8'hA5);
    host_txn(1'b1, 6'h05, 8'h3C, 8'hA5, 1'b0);
    host_txn(1'b0, 6'h05, 8'h00, 8'h3C, 1'b0);
    chk("host_rdata_literal_3c", host.host_rdata, 8'h3C);
    drained("host");

    // host request held from reset through init
    clear_model();
    host.host_rw = 1'b1; host.host_reg = 6'h0A; host.host_wdata = 8'h77; host.host_req = 1'b1;
    push_init(1'b0);
    exp_q.push_back(txn_t'{1'b1, 6'h0A, 8'h77});
    hexp_q.push_back(hrsp_t'{8'h00, 1'b0});
    pulse_reset();
    wait_ack(3000);
    host.host_req = 1'b0;
    chk("early_req_init_done", init_done, 1);
    chk("early_req_send_count", send_cyc.size(), VERIFY ? 5 : 3);
    drained("early_req");

    // entry 0 never acknowledged: timeout, skip, continue
    clear_model();
    stuck_en = 1'b1; stuck_reg = 6'h02;
    push_init(1'b1);
    pulse_reset();
    wait_init(3000);
    chk("timeout_init_error", init_error, 1);
    chk("timeout_send_count", send_cyc.size(), VERIFY ? 3 : 2);
    if (send_cyc.size() >= 2)
      chk("timeout_gap_in_range", (send_cyc[1] - send_cyc[0] >= TIMEOUT) && (send_cyc[1] - send_cyc[0] <= TIMEOUT + 5), 1);
    else
      chk("timeout_gap_sends_seen", send_cyc.size(), 2);
    stuck_reg = 6'h2A;
    host_txn(1'b0, 6'h1F, 8'h00, 8'hA5, 1'b0);
    host_txn(1'b0, 6'h2A, 8'h00, 8'hA5, 1'b1);
    chk("host_timeout_rdata_kept", host.host_rdata, 8'hA5);
    stuck_en = 1'b0;
    drained("timeout");

    // reset in the middle of entry 1
    clear_model();
    push_init(1'b0);
    pulse_reset();
    n = 0;
    while (send_cyc.size() < (VERIFY ? 3 : 2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midframe_entry1_sent", send_cyc.size(), VERIFY ? 3 : 2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midframe_rst_send", spi.spi_send, 0);
    chk("midframe_rst_init_done", init_done, 0);
    chk("midframe_rst_busy", busy, 1);
    chk("midframe_rst_spi_reg", spi.spi_reg, 0);
    clear_model();
    push_init(1'b0);
    reset = 1'b0;
    rst_cyc = cyc;
    wait_init(2000);
    chk("rerun_send_count", send_cyc.size(), VERIFY ? 4 : 2);
    chk("rerun_startup_wait", (send_cyc.size() > 0 && send_cyc[0] - rst_cyc >= STARTUP), 1);
    drained("rerun");

    // readback of reg 03 returns 00
    clear_model();
    corrupt03 = 1'b1;
    push_init(1'b0);
    pulse_reset();
    wait_init(2000);
    chk("corrupt_init_error", init_error, VERIFY ? 1 : 0);
`ifdef DAC_CFG_VERIFY_EN
    chk("corrupt_verify_fail_idx", verify_fail_idx, 1);
`endif
    chk("corrupt_send_count", send_cyc.size(), VERIFY ? 4 : 2);
    corrupt03 = 1'b0;
    drained("corrupt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
